// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared FSM state and PC source-select encodings
package pc_sequencer_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_IRQ = 1'b1
    } seq_state_t;

    // Which source drives pc_next this cycle, in priority order (highest last)
    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_CALL   = 3'd3,
        SRC_RET    = 3'd4,
        SRC_IRET   = 3'd5,
        SRC_IRQ    = 3'd6,
        SRC_HOLD   = 3'd7
    } pc_src_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control inputs and status outputs of the PC sequencer
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            branch_taken;
    logic            jump;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] target;
    logic            irq;
    logic            iret;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            in_irq;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output stall, branch_taken, jump, call, ret, target, irq, iret,
        input  pc, pc_next, in_irq, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, branch_taken, jump, call, ret, target, irq, iret,
        output pc, pc_next, in_irq, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - circular return-address stack with sticky error flags
module ras_stack #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [PW-1:0]   top_ptr;

    assign top_ptr  = wr_ptr - 1'b1;
    assign top_data = mem[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);

    // Entry storage; stale contents are unreachable once count is cleared
    always_ff @(negedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and sticky flags; a push when full overwrites the oldest slot
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                wr_ptr <= top_ptr;
                count  <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return stack and single-level interrupt
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int INC       = 1,
    parameter int RAS_DEPTH = 8,
    parameter int RESET_VEC = 0,
    parameter int IRQ_VEC   = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [PC_W-1:0] INC_V       = PC_W'(INC);
    localparam logic [PC_W-1:0] RESET_VEC_V = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] IRQ_VEC_V   = PC_W'(IRQ_VEC);

    seq_state_t      state;
    pc_src_t         src;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] epc;
    logic            irq_pending;
    logic            in_irq;
    logic            irq_take;
    logic            iret_take;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;

    assign pc_inc    = pc + INC_V;
    assign irq_take  = (bus.irq | irq_pending) & ~bus.stall & (state == ST_RUN);
    assign iret_take = bus.iret & ~bus.stall & (state == ST_IRQ);

    // Priority select of the next PC source
    always_comb begin
        src = SRC_SEQ;
        if (bus.stall)             src = SRC_HOLD;
        else if (irq_take)         src = SRC_IRQ;
        else if (iret_take)        src = SRC_IRET;
        else if (bus.ret)          src = SRC_RET;
        else if (bus.call)         src = SRC_CALL;
        else if (bus.jump)         src = SRC_JUMP;
        else if (bus.branch_taken) src = SRC_BRANCH;
    end

    // Next-PC mux and stack controls; an empty-stack ret falls through to sequential
    always_comb begin
        pc_next  = pc_inc;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        unique case (src)
            SRC_HOLD:   pc_next = pc;
            SRC_IRQ:    pc_next = IRQ_VEC_V;
            SRC_IRET:   pc_next = epc;
            SRC_RET: begin
                ras_pop = 1'b1;
                pc_next = ras_empty ? pc_inc : ras_top;
            end
            SRC_CALL: begin
                ras_push = 1'b1;
                pc_next  = bus.target;
            end
            SRC_JUMP:   pc_next = bus.target;
            SRC_BRANCH: pc_next = bus.target;
            default:    pc_next = pc_inc;
        endcase
    end

    // RUN/IRQ state machine with PC, saved return PC and pending-interrupt latch
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            in_irq      <= 1'b0;
            pc          <= RESET_VEC_V;
            epc         <= '0;
            irq_pending <= 1'b0;
        end else begin
            pc <= pc_next;
            if (irq_take) begin
                irq_pending <= 1'b0;
            end else if (bus.irq) begin
                irq_pending <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (irq_take) begin
                        epc    <= pc_inc;
                        state  <= ST_IRQ;
                        in_irq <= 1'b1;
                    end
                end
                ST_IRQ: begin
                    if (iret_take) begin
                        state  <= ST_RUN;
                        in_irq <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    in_irq <= 1'b0;
                end
            endcase
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .ovf       (bus.ras_ovf),
        .unf       (bus.ras_unf)
    );

    assign bus.pc        = pc;
    assign bus.pc_next   = pc_next;
    assign bus.in_irq    = in_irq;
    assign bus.ras_empty = ras_empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [15:0] pushed [9];

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(16)) bus ();

    pc_sequencer #(
        .PC_W      (16),
        .INC       (1),
        .RAS_DEPTH (8),
        .RESET_VEC (0),
        .IRQ_VEC   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.call = 0;
        bus.ret = 0; bus.irq = 0; bus.iret = 0; bus.target = '0;
    endtask

    // One falling-edge update, then sample on the following rising edge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [15:0] t);
        idle(); bus.jump = 1; bus.target = t;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", 32'(bus.pc), 32'h0000);
        chk("rst_empty", 32'(bus.ras_empty), 32'h1);
        chk("rst_full", 32'(bus.ras_full), 32'h0);
        chk("rst_ovf", 32'(bus.ras_ovf), 32'h0);
        chk("rst_unf", 32'(bus.ras_unf), 32'h0);
        chk("rst_in_irq", 32'(bus.in_irq), 32'h0);
        reset = 1'b0;
        #1;
        chk("pc_next_after_rst", 32'(bus.pc_next), 32'h0001);
        tick(); chk("seq1", 32'(bus.pc), 32'h0001);
        tick(); chk("seq2", 32'(bus.pc), 32'h0002);
        tick(); chk("seq3", 32'(bus.pc), 32'h0003);

        // call / ret round trip
        do_jump(16'h0010);
        chk("jump10", 32'(bus.pc), 32'h0010);
        bus.call = 1; bus.target = 16'h0100;
        #1 chk("pc_next_call", 32'(bus.pc_next), 32'h0100);
        tick(); idle();
        chk("call_pc", 32'(bus.pc), 32'h0100);
        chk("call_nonempty", 32'(bus.ras_empty), 32'h0);
        bus.ret = 1;
        tick(); idle();
        chk("ret_pc", 32'(bus.pc), 32'h0011);
        chk("ret_empty", 32'(bus.ras_empty), 32'h1);

        // nine calls into an eight-deep stack, then nine rets
        do_jump(16'h1000);
        pushed[0] = 16'h1001;
        for (int i = 0; i < 9; i++) begin
            bus.call = 1; bus.target = 16'h2000 + 16'(i) * 16'h0100;
            tick(); idle();
            if (i < 8) pushed[i+1] = 16'h2000 + 16'(i) * 16'h0100 + 16'h1;
        end
        chk("ovf_full", 32'(bus.ras_full), 32'h1);
        chk("ovf_flag", 32'(bus.ras_ovf), 32'h1);
        for (int k = 0; k < 8; k++) begin
            bus.ret = 1;
            tick(); idle();
            chk($sformatf("pop%0d", k), 32'(bus.pc), 32'(pushed[8-k]));
        end
        chk("pop_empty", 32'(bus.ras_empty), 32'h1);
        chk("pop_no_unf", 32'(bus.ras_unf), 32'h0);
        bus.ret = 1;
        tick(); idle();
        chk("unf_pc", 32'(bus.pc), 32'(pushed[1] + 16'h1));
        chk("unf_flag", 32'(bus.ras_unf), 32'h1);

        // irq while stalled, then taken once stall drops
        do_jump(16'h0020);
        bus.stall = 1; bus.irq = 1;
        tick(); idle();
        chk("stall_hold", 32'(bus.pc), 32'h0020);
        chk("stall_no_irq", 32'(bus.in_irq), 32'h0);
        tick();
        chk("irq_vec", 32'(bus.pc), 32'h0004);
        chk("irq_in", 32'(bus.in_irq), 32'h1);
        chk("irq_epc", 32'(dut.epc), 32'h0021);
        tick();
        chk("irq_seq", 32'(bus.pc), 32'h0005);
        bus.irq = 1;
        tick(); idle();
        chk("no_nest_pc", 32'(bus.pc), 32'h0006);
        chk("no_nest_in", 32'(bus.in_irq), 32'h1);
        bus.iret = 1;
        tick(); idle();
        chk("iret_pc", 32'(bus.pc), 32'h0021);
        chk("iret_run", 32'(bus.in_irq), 32'h0);
        tick();
        chk("pend_take", 32'(bus.pc), 32'h0004);
        chk("pend_epc", 32'(dut.epc), 32'h0022);
        bus.iret = 1;
        tick(); idle();
        chk("iret2_pc", 32'(bus.pc), 32'h0022);

        // iret in RUN is ignored; call+ret together only pops
        bus.iret = 1; bus.jump = 1; bus.target = 16'h0030;
        tick(); idle();
        chk("iret_run_ignored", 32'(bus.pc), 32'h0030);
        bus.call = 1; bus.ret = 1; bus.target = 16'h0700;
        tick(); idle();
        chk("callret_pc", 32'(bus.pc), 32'h0031);
        chk("callret_empty", 32'(bus.ras_empty), 32'h1);

        // wrap and redirect priority
        do_jump(16'hFFFF);
        tick();
        chk("wrap", 32'(bus.pc), 32'h0000);
        bus.jump = 1; bus.branch_taken = 1; bus.target = 16'h0040;
        tick(); idle();
        chk("jump_branch", 32'(bus.pc), 32'h0040);
        bus.call = 1; bus.irq = 1; bus.target = 16'h0500;
        tick(); idle();
        chk("irq_over_call", 32'(bus.pc), 32'h0004);
        chk("irq_call_nopush", 32'(bus.ras_empty), 32'h1);
        bus.iret = 1;
        tick(); idle();
        chk("iret3_pc", 32'(bus.pc), 32'h0041);

        // asynchronous reset while in IRQ with three stacked entries
        for (int i = 0; i < 3; i++) begin
            bus.call = 1; bus.target = 16'h0300 + 16'(i);
            tick(); idle();
        end
        bus.irq = 1;
        tick(); idle();
        chk("pre_rst_in_irq", 32'(bus.in_irq), 32'h1);
        chk("pre_rst_nonempty", 32'(bus.ras_empty), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_pc", 32'(bus.pc), 32'h0000);
        chk("async_in_irq", 32'(bus.in_irq), 32'h0);
        chk("async_empty", 32'(bus.ras_empty), 32'h1);
        chk("async_epc", 32'(dut.epc), 32'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        chk("post_rst_seq", 32'(bus.pc), 32'h0001);
        bus.ret = 1;
        tick(); idle();
        chk("post_rst_ret_empty", 32'(bus.pc), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 16: PC and all address widths.
REQ-002 Parameter INC, default 1: sequential PC increment.
REQ-003 Parameter RAS_DEPTH, default 8, power of two >= 2: return-address stack entries.
REQ-004 Parameter RESET_VEC, default 0: PC value after reset.
REQ-005 Parameter IRQ_VEC, default 4: interrupt handler entry address.
REQ-006 clk  in  1  clock; all state updates on falling edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 stall  in  1  hold all state this cycle.
REQ-009 branch_taken  in  1  conditional redirect to target.
REQ-010 jump  in  1  unconditional redirect to target.
REQ-011 call  in  1  push return address, redirect to target.
REQ-012 ret  in  1  pop return address into PC.
REQ-013 target  in  PC_W  redirect address for branch/jump/call.
REQ-014 irq  in  1  interrupt request, level or pulse.
REQ-015 iret  in  1  return from interrupt.
REQ-016 pc  out  PC_W  current PC, registered.
REQ-017 pc_next  out  PC_W  combinational value pc takes at next falling edge.
REQ-018 in_irq  out  1  FSM in IRQ state.
REQ-019 ras_empty / ras_full  out  1 each  stack occupancy flags.
REQ-020 ras_ovf / ras_unf  out  1 each  sticky overflow/underflow flags.

Function
REQ-021 Without stall, pc is updated every falling edge from the highest-priority active source: irq_take > iret > ret > call > jump > branch_taken > sequential.
REQ-022 Sequential: pc + INC, truncated to PC_W; 0xFFFF + 1 wraps to 0x0000.
REQ-023 When stall=1: pc, RAS, FSM and EPC hold; an irq arriving during stall is latched in irq_pending.
REQ-024 call: pushes pc + INC (wrapped) and loads pc <= target.
REQ-025 ret, stack non-empty: pops top of stack into pc.
REQ-026 ret, stack empty: pc <= pc + INC; ras_unf set; occupancy stays 0.
REQ-027 Stack is circular. call while full overwrites the oldest entry, keeps count at RAS_DEPTH, and sets ras_ovf.
REQ-028 FSM has two states, RUN and IRQ; reset enters RUN.
REQ-029 RUN to IRQ: irq_take = (irq | irq_pending) & ~stall. Effects: EPC <= the address sequential flow would have taken (pc + INC); pc <= IRQ_VEC; irq_pending cleared.
REQ-030 In IRQ state, irq is latched into irq_pending but not taken; no nesting.
REQ-031 IRQ to RUN: on iret, pc <= EPC.
REQ-032 iret in RUN is ignored and falls to the next priority source.
REQ-033 Same-cycle call and ret: only ret acts; no push.
REQ-034 Any redirect occurring together with irq_take is discarded.
REQ-035 pc_next always equals the value pc holds after the next non-reset falling edge.

Reset
REQ-036 While reset is high, all outputs and state are forced asynchronously: pc = RESET_VEC, RAS occupancy = 0, ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0, FSM = RUN, in_irq = 0, EPC = 0, irq_pending = 0.
REQ-037 Reset asserted mid-call or mid-interrupt discards all stack contents and the saved EPC.
REQ-038 The first update after deassertion occurs on the next falling edge.

Structure
REQ-039 Shared package holds the FSM state enum (RUN, IRQ) and the PC source-select encoding.
REQ-040 The return-address stack is one sub-module, ras_stack, with push, pop, data and flags, parameterised by PC_W and RAS_DEPTH.
REQ-041 Priority selection and the FSM stay in pc_sequencer.

Verification
REQ-042 Reset release, no inputs for 3 falling edges -> pc = 0x0000, 0x0001, 0x0002, 0x0003.
REQ-043 pc = 0x0010, call target = 0x0100, then ret -> pc = 0x0100 then 0x0011; ras_empty = 1.
REQ-044 9 calls with RAS_DEPTH = 8, then 9 rets -> ras_ovf = 1; first 8 pops return the newest 8 addresses; 9th ret gives sequential pc and sets ras_unf.
REQ-045 pc = 0x0020, irq pulse while stall = 1, stall released -> pc = 0x0004, EPC = 0x0021, in_irq = 1; iret -> pc = 0x0021.
REQ-046 pc = 0xFFFF, no redirect -> pc = 0x0000; jump and branch_taken together with target 0x0040 -> pc = 0x0040.
REQ-047 Reset asserted asynchronously between edges while in_irq = 1 with 3 stack entries -> pc = 0x0000, in_irq = 0, ras_empty = 1 immediately, before any clock edge.
